score_ctrl: RTL



---
 rtl/score_ctrl.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/score_ctrl.sv
// Game score/phase controller with a sequential shift-add-3 BCD engine.
// Optional `HIGH_SCORE_EN adds a high-score register and a second BCD pass.
module score_ctrl #(
  parameter int SCORE_BITS  = 10,
  parameter int MAX_SCORE   = 999,
  parameter int MOVE_PERIOD = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_move,
  input  logic                  i_game_over,
  input  logic                  i_restart,
  output logic [SCORE_BITS-1:0] o_score,
  output logic [1:0]            o_state,
  output logic [3:0]            o_hundreds,
  output logic [3:0]            o_tens,
  output logic [3:0]            o_ones,
`ifdef HIGH_SCORE_EN
  output logic [SCORE_BITS-1:0] o_high_score,
  output logic [3:0]            o_hi_hundreds,
  output logic [3:0]            o_hi_tens,
  output logic [3:0]            o_hi_ones,
`endif
  output logic                  o_bcd_done
);

  localparam int HW =
    (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int CW = $clog2(SCORE_BITS + 1);
  localparam logic [HW-1:0] HOLD_TOP =
    HW'(MOVE_PERIOD - 1);
  localparam logic [SCORE_BITS-1:0] MAX_S =
    SCORE_BITS'(MAX_SCORE);
  localparam logic [CW-1:0] CNT_TOP =
    CW'(SCORE_BITS - 1);

  typedef enum logic [1:0] {
    G_IDLE = 2'b00,
    G_RUN  = 2'b01,
    G_OVER = 2'b10
  } game_e;

  typedef enum logic [1:0] {
    B_IDLE  = 2'b00,
    B_SHIFT = 2'b01,
    B_DONE  = 2'b10
  } bcd_e;

  game_e state_q, state_d;
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic [HW-1:0] hold_q, hold_d;

  bcd_e bst_q, bst_d;
  logic [SCORE_BITS-1:0] bin_q, bin_d;
  logic [11:0] sh_q, sh_d;
  logic [11:0] adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0] dig_q, dig_d;
  logic done_q, done_d;

`ifdef HIGH_SCORE_EN
  logic [SCORE_BITS-1:0] high_q, high_d;
  logic [11:0] tmp_q, tmp_d;
  logic [11:0] hdig_q, hdig_d;
  logic pass_q, pass_d;
`endif

  function automatic logic [11:0] add3(
    input logic [11:0] v
  );
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5)
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Game phase and score accumulation
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    hold_d  = hold_q;
`ifdef HIGH_SCORE_EN
    high_d  = high_q;
`endif
    unique case (state_q)
      G_IDLE: begin
        if (i_restart) begin
          state_d = G_RUN;
          score_d = '0;
          hold_d  = '0;
        end
      end
      G_RUN: begin
        if (i_game_over) begin
          state_d = G_OVER;
`ifdef HIGH_SCORE_EN
          if (score_q > high_q)
            high_d = score_q;
`endif
        end else if (i_frame_start) begin
          if (!i_move) begin
            hold_d = '0;
          end else if (hold_q == HOLD_TOP) begin
            hold_d = '0;
            if (score_q < MAX_S)
              score_d = score_q + SCORE_BITS'(1);
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      G_OVER: begin
        if (i_restart) begin
          state_d = G_RUN;
          score_d = '0;
          hold_d  = '0;
        end
      end
      default: state_d = G_IDLE;
    endcase
  end

  // Double-dabble engine; snapshot is the pre-increment score
  always_comb begin
    bst_d  = bst_q;
    bin_d  = bin_q;
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    done_d = 1'b0;
    adj    = add3(sh_q);
`ifdef HIGH_SCORE_EN
    tmp_d  = tmp_q;
    hdig_d = hdig_q;
    pass_d = pass_q;
`endif
    unique case (bst_q)
      B_IDLE: begin
        if (i_frame_start) begin
          bin_d = score_q;
          sh_d  = '0;
          cnt_d = '0;
          bst_d = B_SHIFT;
`ifdef HIGH_SCORE_EN
          pass_d = 1'b0;
`endif
        end
      end
      B_SHIFT: begin
        sh_d  = (adj << 1)
              | 12'(bin_q[SCORE_BITS-1]);
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_TOP)
          bst_d = B_DONE;
      end
      B_DONE: begin
`ifdef HIGH_SCORE_EN
        if (!pass_q) begin
          tmp_d  = sh_q;
          bin_d  = high_q;
          sh_d   = '0;
          cnt_d  = '0;
          pass_d = 1'b1;
          bst_d  = B_SHIFT;
        end else begin
          dig_d  = tmp_q;
          hdig_d = sh_q;
          done_d = 1'b1;
          pass_d = 1'b0;
          bst_d  = B_IDLE;
        end
`else
        dig_d  = sh_q;
        done_d = 1'b1;
        bst_d  = B_IDLE;
`endif
      end
      default: bst_d = B_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= G_IDLE;
      score_q <= '0;
      hold_q  <= '0;
      bst_q   <= B_IDLE;
      bin_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      done_q  <= 1'b0;
`ifdef HIGH_SCORE_EN
      high_q  <= '0;
      tmp_q   <= '0;
      hdig_q  <= '0;
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      hold_q  <= hold_d;
      bst_q   <= bst_d;
      bin_q   <= bin_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      done_q  <= done_d;
`ifdef HIGH_SCORE_EN
      high_q  <= high_d;
      tmp_q   <= tmp_d;
      hdig_q  <= hdig_d;
      pass_q  <= pass_d;
`endif
    end
  end

  assign o_score    = score_q;
  assign o_state    = state_q;
  assign o_hundreds = dig_q[11:8];
  assign o_tens     = dig_q[7:4];
  assign o_ones     = dig_q[3:0];
  assign o_bcd_done = done_q;
`ifdef HIGH_SCORE_EN
  assign o_high_score  = high_q;
  assign o_hi_hundreds = hdig_q[11:8];
  assign o_hi_tens     = hdig_q[7:4];
  assign o_hi_ones     = hdig_q[3:0];
`endif

endmodule
